spi_esclavo: RTL
================

Name: spi_esclavo

Overview:
SPI peripheral (slave) endpoint. It is the far end of the team's SPI master controller and operates in mode 0 (CPOL=0, CPHA=0), MSB first.
- Oversamples sclk_i, cs_i and MOSI on the system clock.
- Deserialises MOSI into received words and serialises a host-supplied word onto MISO.
- Host side uses valid/ready handshakes plus sticky error flags.
- Used in the loopback bench against the master and as a reusable peripheral front-end.

Parameters:
DATA_WIDTH, 8, bits per SPI word (range 4..32).
SYNC_STAGES, 2, synchroniser flops on sclk_i, cs_i and MOSI (minimum 2).

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_i  in  1  reset, synchronous, active-high.
sclk_i  in  1  SPI serial clock from master (asynchronous to clk_i).
cs_i  in  1  chip select from master, active low.
MOSI  in  1  master out, slave in.
MISO  out  1  slave out, master in.
tx_data_i  in  DATA_WIDTH  next word to transmit.
tx_valid_i  in  1  tx_data_i valid.
tx_ready_o  out  1  holding register empty; a word is accepted when tx_valid_i and tx_ready_o are both high.
rx_data_o  out  DATA_WIDTH  last complete received word.
rx_valid_o  out  1  rx_data_o holds an unread word; level signal.
rx_ack_i  in  1  host consumed rx_data_o.
clr_flags_i  in  1  clears overrun_o and underrun_o.
overrun_o  out  1  sticky: a word completed while rx_valid_o was already high.
underrun_o  out  1  sticky: a word started with the holding register empty.
busy_o  out  1  cs_i (synchronised) is low.

Behaviour:
- Timing constraint: every sclk_i high or low phase lasts at least SYNC_STAGES+2 clk_i cycles. Faster clocks are out of spec and unchecked.
- Edge detection uses the synchronised signals only. "Rise", "fall", "cs_fall" and "cs_rise" each refer to one clk_i cycle after the synchroniser output.
- FSM states:
  - ESPERA: cs high. MISO=0 and the bit counter is held at 0.
  - TRANSFER: cs low.
  - ESPERA→TRANSFER on cs_fall. TRANSFER→ESPERA on cs_rise.
- Word start happens in two cases: on cs_fall, and on the sclk fall following the DATA_WIDTH-th sclk rise of a word.
  - At word start the shift_tx register loads the holding register and tx_ready_o returns to 1.
  - If the holding register is empty, shift_tx loads all zeros and underrun_o is set.
  - MISO = shift_tx MSB, valid from word start.
- On each sclk rise in TRANSFER:
  - MOSI is shifted into shift_rx LSB.
  - The bit counter increments modulo DATA_WIDTH.
- On each non-word-start sclk fall: shift_tx shifts left by one, zero-filled.
- Word completion happens on the DATA_WIDTH-th rise. One cycle later:
  - rx_data_o is updated from shift_rx and rx_valid_o=1.
  - If rx_valid_o was already 1 and rx_ack_i is low that cycle, overrun_o is set and the data is overwritten.
- rx_valid_o clears on rx_ack_i. If rx_ack_i coincides with a completion, the completion wins: rx_valid_o stays 1 and no overrun is flagged.
- tx holding register:
  - A write (tx_valid_i and tx_ready_o both high) sets tx_ready_o=0 on the next cycle.
  - A write in the same cycle as a word start is stored and kept for the following word. It is not bypassed into shift_tx.
- Flag clearing: clr_flags_i clears both flags. A set event in the same cycle has priority over the clear.
- cs_rise mid-word:
  - The partial word is discarded: no rx_valid_o, bit counter returns to 0, MISO=0.
  - The holding register is unaffected.
- Reset, applied any time including mid-transfer:
  - State goes to ESPERA. MISO=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, both flags=0, busy_o=0.
  - Shift registers and the holding register are cleared.
  - The synchroniser flops reset to the idle levels: cs=1, sclk=0, MOSI=0.

Optional Feature:
SPI_ESCLAVO_CONTADOR_EN
- Defined: adds output n_rx_o [9:0], the count of complete words received in the current cs frame.
  - Cleared on cs_fall and on reset.
  - Saturates at 1023.
  - Holds its value after cs_rise until the next cs_fall.
- Undefined: the port and its counter are absent.

Decomposition:
- Package spi_pkg holds:
  - the state enum typedef (ESPERA, TRANSFER);
  - the constant SPI_DEFAULT_WIDTH=8;
  - the constant SPI_SYNC_MIN=2.
- One sub-module: sincronizador_spi. It is a parameterised N-stage synchroniser with reset value plus rise/fall pulse outputs, and is instantiated three times.

Test Plan:
- Reset, then cs low, 8 mode-0 clocks with MOSI=0xA5 and tx holding 0x3C → MISO bits 0x3C MSB first; rx_data_o=0xA5 with a rx_valid_o rise.
- Two back-to-back words without cs release, tx 0x11 then 0x22 (second written after first word start) → MISO shows 0x11,0x22; no underrun_o.
- Holding register empty at cs_fall → MISO all zero for the word; underrun_o=1 until clr_flags_i.
- Two words received without rx_ack_i → overrun_o=1, rx_data_o=second word. Repeat with rx_ack_i on the completion cycle → overrun_o=0.
- cs_rise after 5 bits, then a new full word 0xF0 → only 0xF0 is reported and the partial word is never valid.
- rst_i asserted mid-word → all outputs at reset values the next cycle; a subsequent clean frame transfers correctly.
- With SPI_ESCLAVO_CONTADOR_EN defined, 3 words in one frame → n_rx_o=3; it resets to 0 on the next cs_fall.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral endpoint.
package spi_pkg;

   localparam int unsigned SPI_DEFAULT_WIDTH = 8;
   localparam int unsigned SPI_SYNC_MIN      = 2;

   typedef enum logic {
      ESPERA   = 1'b0,
      TRANSFER = 1'b1
   } estado_t;

endpackage

// File: rtl/sincronizador_spi.sv
// N-stage synchroniser with a configurable reset level.
// Produces registered rise/fall pulses one cycle after the synchronised output.
module sincronizador_spi
   import spi_pkg::*;
#(
   parameter int unsigned STAGES  = SPI_SYNC_MIN,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
      prev_d = sync_q[STAGES-1];
      rise_d = sync_q[STAGES-1] & ~prev_q;
      fall_d = ~sync_q[STAGES-1] & prev_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_esclavo.sv
// SPI mode-0 peripheral endpoint, MSB first, oversampled on clk_i.
// Optional frame word counter output n_rx_o under SPI_ESCLAVO_CONTADOR_EN.
module spi_esclavo
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = SPI_DEFAULT_WIDTH,
   parameter int unsigned SYNC_STAGES = SPI_SYNC_MIN
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  sclk_i,
   input  logic                  cs_i,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ack_i,
   input  logic                  clr_flags_i,
   output logic                  overrun_o,
   output logic                  underrun_o,
   output logic                  busy_o
`ifdef SPI_ESCLAVO_CONTADOR_EN
   ,
   output logic [9:0]            n_rx_o
`endif
);

   localparam int unsigned    CW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0]  ULTIMO = CW'(DATA_WIDTH - 1);

   logic cs_sync, cs_fall, cs_rise;
   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   sincronizador_spi #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (cs_i),
      .q_o   (cs_sync), .rise_o (cs_rise), .fall_o (cs_fall)
   );

   sincronizador_spi #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (sclk_i),
      .q_o   (sclk_lvl_unused), .rise_o (sclk_rise), .fall_o (sclk_fall)
   );

   sincronizador_spi #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (MOSI),
      .q_o   (mosi_sync), .rise_o (mosi_rise_unused), .fall_o (mosi_fall_unused)
   );

   estado_t               state_q, state_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
   logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  tx_ready_q, tx_ready_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  overrun_q, overrun_d;
   logic                  underrun_q, underrun_d;
   logic                  fin_q, fin_d;
   logic                  busy_q, busy_d;
   logic                  word_start;
`ifdef SPI_ESCLAVO_CONTADOR_EN
   logic [9:0]            n_rx_q, n_rx_d;
`endif

   // fin_q marks that the last rise completed a word, so the next fall starts one
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_rx_d = shift_rx_q;
      shift_tx_d = shift_tx_q;
      hold_d     = hold_q;
      tx_ready_d = tx_ready_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      underrun_d = underrun_q;
      fin_d      = fin_q;
      busy_d     = ~cs_sync;
      word_start = 1'b0;
`ifdef SPI_ESCLAVO_CONTADOR_EN
      n_rx_d     = n_rx_q;
`endif

      if (clr_flags_i) begin
         overrun_d  = 1'b0;
         underrun_d = 1'b0;
      end
      if (rx_ack_i) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         ESPERA: begin
            bit_cnt_d = '0;
            if (cs_fall) begin
               state_d    = TRANSFER;
               word_start = 1'b1;
               fin_d      = 1'b0;
`ifdef SPI_ESCLAVO_CONTADOR_EN
               n_rx_d     = '0;
`endif
            end
         end
         TRANSFER: begin
            if (cs_rise) begin
               state_d    = ESPERA;
               bit_cnt_d  = '0;
               shift_rx_d = '0;
               shift_tx_d = '0;
               fin_d      = 1'b0;
            end else begin
               if (sclk_rise) begin
                  shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], mosi_sync};
                  if (bit_cnt_q == ULTIMO) begin
                     bit_cnt_d  = '0;
                     fin_d      = 1'b1;
                     rx_data_d  = shift_rx_d;
                     rx_valid_d = 1'b1;
                     if (rx_valid_q && !rx_ack_i) begin
                        overrun_d = 1'b1;
                     end
`ifdef SPI_ESCLAVO_CONTADOR_EN
                     if (n_rx_q != 10'h3FF) begin
                        n_rx_d = n_rx_q + 10'd1;
                     end
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end
               if (sclk_fall) begin
                  if (fin_q) begin
                     word_start = 1'b1;
                     fin_d      = 1'b0;
                  end else begin
                     shift_tx_d = shift_tx_q << 1;
                  end
               end
            end
         end
         default: state_d = ESPERA;
      endcase

      // A write in the word-start cycle sees the old (empty) holding register
      if (word_start) begin
         if (!tx_ready_q) begin
            shift_tx_d = hold_q;
            tx_ready_d = 1'b1;
         end else begin
            shift_tx_d = '0;
            underrun_d = 1'b1;
         end
      end
      if (tx_valid_i && tx_ready_q) begin
         hold_d     = tx_data_i;
         tx_ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ESPERA;
         bit_cnt_q  <= '0;
         shift_rx_q <= '0;
         shift_tx_q <= '0;
         hold_q     <= '0;
         tx_ready_q <= 1'b1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
         fin_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SPI_ESCLAVO_CONTADOR_EN
         n_rx_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_rx_q <= shift_rx_d;
         shift_tx_q <= shift_tx_d;
         hold_q     <= hold_d;
         tx_ready_q <= tx_ready_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
         fin_q      <= fin_d;
         busy_q     <= busy_d;
`ifdef SPI_ESCLAVO_CONTADOR_EN
         n_rx_q     <= n_rx_d;
`endif
      end
   end

   assign MISO       = shift_tx_q[DATA_WIDTH-1];
   assign tx_ready_o = tx_ready_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign overrun_o  = overrun_q;
   assign underrun_o = underrun_q;
   assign busy_o     = busy_q;
`ifdef SPI_ESCLAVO_CONTADOR_EN
   assign n_rx_o     = n_rx_q;
`endif

endmodule
